// File: rtl/hist_lut_builder.sv
`default_nettype none
// ============================================================================
// Module   : hist_lut_builder
// Purpose  : Builds a 256-bin histogram over one frame of 8-bit pixels. It
//            then accumulates the CDF and writes a 256-entry histogram
//            equalisation LUT. The LUT can be read through a registered port.
// Revision : 1.0 - initial release
// ============================================================================
module hist_lut_builder #(
    parameter int unsigned IMAGE_SIZE = 640 * 480,
    parameter int unsigned CNT_W      = $clog2(IMAGE_SIZE + 1),
    parameter int unsigned SCALE      =
        32'(((64'd255 << 24) + 64'(IMAGE_SIZE / 2)) / 64'(IMAGE_SIZE))
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [7:0] i_pix_data,
    input  logic       i_pix_valid,
    output logic       o_pix_ready,
    output logic       o_busy,
    output logic       o_done,
    input  logic [7:0] i_lut_addr,
    output logic [7:0] o_lut_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_CDF   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int unsigned PROD_W    = CNT_W + 25;
    localparam logic [24:0] SCALE_Q24 = 25'(SCALE);

    // Storage: the bin counters and the LUT. Neither is reset.
    logic [CNT_W-1:0] bin_mem [256];
    logic [7:0]       lut_mem [256];

    state_t           state_q, state_d;
    logic [8:0]       idx_q, idx_d;          // CLEAR address / CDF read index
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] cdf_q, cdf_d;

    // Histogram pipeline: stage 1 holds the pixel whose bin is being read.
    // The fw_* registers hold the increment written on the previous edge.
    // A synchronous read cannot see that write yet.
    logic             s1_valid_q;
    logic [7:0]       s1_pix_q;
    logic             fw_valid_q;
    logic [7:0]       fw_pix_q;
    logic [CNT_W-1:0] fw_cnt_q;
    logic [CNT_W-1:0] rd_q;                  // shared bin read data

    // CDF pipeline: c1 = bin read returned, c2 = cumulative sum ready.
    logic             c1_valid_q, c2_valid_q;
    logic [7:0]       c1_idx_q, c2_idx_q;

    logic             w_xfer;
    logic [7:0]       w_rd_addr;
    logic [CNT_W-1:0] w_inc;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_scaled;
    logic [7:0]       w_lut;

    assign o_pix_ready = (state_q == S_ACCUM);
    assign o_busy      = (state_q == S_CLEAR) || (state_q == S_ACCUM) ||
                         (state_q == S_DRAIN) || (state_q == S_CDF);
    assign o_done      = (state_q == S_DONE);
    assign w_xfer      = i_pix_valid && o_pix_ready;
    assign w_rd_addr   = (state_q == S_CDF) ? idx_q[7:0] : i_pix_data;

    // Forward the value written last cycle when the same bin is read again.
    assign w_inc    = ((fw_valid_q && (fw_pix_q == s1_pix_q)) ? fw_cnt_q : rd_q)
                      + CNT_W'(1);
    assign w_prod   = PROD_W'(cdf_q) * PROD_W'(SCALE_Q24);
    assign w_scaled = w_prod >> 24;
    assign w_lut    = (w_scaled > PROD_W'(255)) ? 8'hFF : w_scaled[7:0];

    // State register and the per-run counters.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pix_cnt_q <= '0;
            cdf_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pix_cnt_q <= pix_cnt_d;
            cdf_q     <= cdf_d;
        end
    end

    // Next-state logic: sequence CLEAR, ACCUM, DRAIN and CDF for one frame.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pix_cnt_d = pix_cnt_q;
        cdf_d     = cdf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d   = S_CLEAR;
                    idx_d     = '0;
                    pix_cnt_d = '0;
                    cdf_d     = '0;
                end
            end
            S_CLEAR: begin
                if (idx_q == 9'd255) begin
                    state_d = S_ACCUM;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
            S_ACCUM: begin
                if (w_xfer) begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == CNT_W'(IMAGE_SIZE - 1)) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (idx_q == 9'd1) begin
                    state_d = S_CDF;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
            S_CDF: begin
                if (!idx_q[8]) begin
                    idx_d = idx_q + 9'd1;
                end
                if (c1_valid_q) begin
                    cdf_d = cdf_q + rd_q;
                end
                if (c2_valid_q && (c2_idx_q == 8'd255)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pipeline valids and tags, plus the registered LUT read port.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            fw_valid_q <= 1'b0;
            fw_pix_q   <= '0;
            fw_cnt_q   <= '0;
            c1_valid_q <= 1'b0;
            c1_idx_q   <= '0;
            c2_valid_q <= 1'b0;
            c2_idx_q   <= '0;
            o_lut_data <= '0;
        end else begin
            s1_valid_q <= w_xfer;
            s1_pix_q   <= i_pix_data;
            fw_valid_q <= s1_valid_q;
            fw_pix_q   <= s1_pix_q;
            fw_cnt_q   <= w_inc;
            c1_valid_q <= (state_q == S_CDF) && !idx_q[8];
            c1_idx_q   <= idx_q[7:0];
            c2_valid_q <= c1_valid_q;
            c2_idx_q   <= c1_idx_q;
            o_lut_data <= lut_mem[i_lut_addr];
        end
    end

    // Memory ports: one bin read, one bin write (clear or increment), one LUT write.
    always_ff @(posedge i_clk) begin
        rd_q <= bin_mem[w_rd_addr];
        if (state_q == S_CLEAR) begin
            bin_mem[idx_q[7:0]] <= '0;
        end else if (s1_valid_q) begin
            bin_mem[s1_pix_q] <= w_inc;
        end
        if (c2_valid_q) begin
            lut_mem[c2_idx_q] <= w_lut;
        end
    end

endmodule
`default_nettype wire

// File: doc/hist_lut_builder.md
Name: hist_lut_builder

Overview:
- Downstream consumer of the DDR image reader's 8-bit pixel stream; first compute stage of histogram equalization.
- Counts a 256-bin histogram over exactly IMAGE_SIZE pixels, then accumulates the CDF and writes a 256-entry equalization LUT.
- The LUT is readable through a synchronous port by the pixel-remap stage.

Parameters:
- IMAGE_SIZE, 640*480, pixels per frame; the histogram closes after this many accepted pixels.
- CNT_W, $clog2(IMAGE_SIZE+1), width of bin counters, CDF accumulator and pixel counter.
- SCALE, round(255*2^24/IMAGE_SIZE), fixed-point CDF-to-intensity scale (Q24).

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; honoured only in IDLE or DONE.
- i_pix_data  in  8  pixel value.
- i_pix_valid  in  1  pixel valid.
- o_pix_ready  out  1  block accepts a pixel; a transfer happens when i_pix_valid & o_pix_ready.
- o_busy  out  1  high in CLEAR, ACCUM, DRAIN and CDF.
- o_done  out  1  LUT valid; level, held until the next accepted start or reset.
- i_lut_addr  in  8  LUT read address.
- o_lut_data  out  8  LUT read data, one-cycle latency.

Behaviour:
- Reset (async, i_reset_n low):
  - State goes to IDLE; o_pix_ready, o_busy, o_done and o_lut_data = 0; pixel counter, CDF and pipeline valids = 0.
  - Bin and LUT RAMs are not reset.
- States: IDLE -> CLEAR -> ACCUM -> DRAIN -> CDF -> DONE.
  - IDLE: wait for i_start; then go to CLEAR and drop o_done.
  - DONE: wait for i_start; then go to CLEAR and drop o_done.
  - CLEAR: write 0 to bins 0..255, one per cycle (256 cycles), then go to ACCUM.
  - ACCUM:
    - o_pix_ready = 1 while accepted count < IMAGE_SIZE.
    - When the transfer that makes count == IMAGE_SIZE occurs, o_pix_ready drops the next cycle and the state goes to DRAIN.
    - Further valid pixels are never consumed.
  - DRAIN: 2 cycles to retire the in-flight increments, then go to CDF.
  - CDF:
    - Index i runs 0..255, one per cycle.
    - Read bin[i] and add to the running sum: cdf = cdf + bin[i], CNT_W bits (cannot overflow because the sum is at most IMAGE_SIZE).
    - lut[i] = min(255, (cdf*SCALE) >> 24); the product width is CNT_W+25.
    - After the last LUT write (pipeline ≤ 3 cycles), go to DONE and set o_done = 1.
  - i_start is ignored while o_busy = 1.
- Histogram pipeline:
  - Throughput is 1 pixel/cycle with back-to-back valid.
  - Stage 1: read bin[pix]. Stage 2: write bin[pix] + 1.
  - Forwarding is mandatory. When an incoming pixel matches a pixel in either in-flight stage, the forwarded count is used instead of the stale RAM value.
  - Consecutive identical pixels, and identical pixels separated by one gap or one other pixel, must count exactly.
  - Bin counters are CNT_W wide; no saturation is needed.
- LUT port:
  - o_lut_data <= lut[i_lut_addr] every cycle, registered.
  - Content is defined only while o_done = 1.
- Reset mid-operation (any state) aborts the run.
  - Outputs go low at once (async).
  - The next i_start performs a full CLEAR, so no residue from the aborted run remains.
- Latency from i_start (IDLE) to o_done:
  - At least 256 + IMAGE_SIZE + 2 + 256 + pipeline cycles.
  - At most 3 extra cycles of pipeline, independent of pixel gaps other than ACCUM stretch.

Test Plan:
- IMAGE_SIZE=1024, SCALE=4177920, 1024 back-to-back pixels all 0x80 -> lut[0..127]=0, lut[128..255]=255, o_done=1, o_pix_ready low after the 1024th transfer.
- IMAGE_SIZE=1024, ramp pixel=(k/4)%256, k=0..1023, continuous valid -> lut[v]=v for v=0..254, lut[255]=255.
- IMAGE_SIZE=1024, pattern 5,5,6,5,7,7,7,6 repeated with random 0-2 cycle valid gaps -> bin5=384, bin6=256, bin7=384 (forwarding). lut[4]=0, lut[5]=95, lut[6]=159, lut[7]=255.
- IMAGE_SIZE=1024, hold i_pix_valid high with 1100 pixels offered -> exactly 1024 accepted, o_pix_ready=0 for the remainder, result identical to scenario 1 data.
- i_start pulsed during ACCUM -> ignored, result unchanged. i_start in DONE -> o_done falls next cycle, CLEAR reruns, new frame result correct.
- i_reset_n low for 2 cycles after 500 pixels in ACCUM -> o_pix_ready, o_busy, o_done = 0 asynchronously. A following start plus the scenario 2 stimulus gives the scenario 2 LUT.
